feature_frame_accum: RTL

- Multi-channel per-frame pixel-hit accumulator for camera/VGA feature detectors; generalises the single-channel pipe-corner frame summer.
- Sits between the per-pixel matchers, which supply NUM_CH detect bits, and the game-control logic.
- Counts qualifying detect pixels per channel inside a window, then latches the counts at the frame boundary.
- Produces per-channel found flags with threshold plus frame hysteresis, and last-hit coordinates.

---
 rtl/feature_frame_accum.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/feature_frame_accum.sv
`default_nettype none
// ============================================================================
//  Module   : feature_frame_accum
//  Purpose  : Per-channel windowed pixel-hit counter with frame-boundary latch,
//             threshold/hysteresis found flags and last-hit coordinates.
//             Optional FEATURE_BBOX_EN adds per-channel bounding-box outputs.
//  Revision : 1.0  initial release
// ============================================================================
module feature_frame_accum #(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CNT_W       = 12,
    parameter int unsigned X_MIN       = 0,
    parameter int unsigned X_MAX       = 640,
    parameter int unsigned Y_MAX       = 479,
    parameter int unsigned THRESH      = 1,
    parameter int unsigned HOLD_FRAMES = 2
) (
    input  logic                    OSC_27,
    input  logic                    RESET_N,
    input  logic                    Shift_En,
    input  logic [9:0]              VGA_X,
    input  logic [9:0]              VGA_Y,
    input  logic [NUM_CH-1:0]       det,
    output logic [NUM_CH*CNT_W-1:0] frame_count,
    output logic [NUM_CH-1:0]       found,
    output logic [NUM_CH*10-1:0]    hit_x,
    output logic [NUM_CH*10-1:0]    hit_y,
    output logic [NUM_CH-1:0]       hit_valid,
    output logic                    new_frame
`ifdef FEATURE_BBOX_EN
    ,
    output logic [NUM_CH*10-1:0]    bbox_xmin,
    output logic [NUM_CH*10-1:0]    bbox_xmax,
    output logic [NUM_CH*10-1:0]    bbox_ymin,
    output logic [NUM_CH*10-1:0]    bbox_ymax
`endif
);

    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] c_THRESH   = CNT_W'(THRESH);
    localparam logic [10:0]      c_X_MIN    = 11'(X_MIN);
    localparam logic [10:0]      c_X_MAX    = 11'(X_MAX);
    localparam logic [10:0]      c_Y_MAX    = 11'(Y_MAX);
    localparam logic [3:0]       c_HOLD_MAX = 4'd15;
    localparam logic [3:0]       c_HOLD_LIM = 4'(HOLD_FRAMES);
`ifdef FEATURE_BBOX_EN
    localparam logic [9:0]       c_MIN_RST  = 10'd1023;
`endif

    logic w_boundary;
    logic w_in_win;
    logic w_qual;
    logic new_frame_q;

    // (0,0) is deliberately not the boundary; the latch happens one pixel in.
    assign w_boundary = Shift_En && (VGA_X == 10'd1) && (VGA_Y == 10'd1);
    assign w_in_win   = ({1'b0, VGA_X} > c_X_MIN) && ({1'b0, VGA_X} < c_X_MAX) &&
                        ({1'b0, VGA_Y} < c_Y_MAX);
    assign w_qual     = Shift_En && !w_boundary && w_in_win;

    always_ff @(posedge OSC_27 or negedge RESET_N) begin
        if (!RESET_N) new_frame_q <= 1'b0;
        else          new_frame_q <= w_boundary;
    end
    assign new_frame = new_frame_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             w_hit;
        logic [CNT_W-1:0] acc_q, acc_d, fc_q, fc_d;
        logic [9:0]       run_x_q, run_x_d, run_y_q, run_y_d;
        logic [9:0]       hx_q, hx_d, hy_q, hy_d;
        logic             run_v_q, run_v_d, hv_q, hv_d, found_q, found_d;
        logic [3:0]       hold_q, hold_d, w_hold_inc;
`ifdef FEATURE_BBOX_EN
        logic [9:0]       mnx_q, mnx_d, mxx_q, mxx_d, mny_q, mny_d, mxy_q, mxy_d;
        logic [9:0]       bxn_q, bxn_d, bxx_q, bxx_d, byn_q, byn_d, byx_q, byx_d;
`endif

        assign w_hit = w_qual && det[c];

        always_comb begin
            acc_d      = acc_q;
            fc_d       = fc_q;
            run_x_d    = run_x_q;
            run_y_d    = run_y_q;
            run_v_d    = run_v_q;
            hx_d       = hx_q;
            hy_d       = hy_q;
            hv_d       = hv_q;
            found_d    = found_q;
            hold_d     = hold_q;
            w_hold_inc = (hold_q == c_HOLD_MAX) ? hold_q : hold_q + 4'd1;
`ifdef FEATURE_BBOX_EN
            mnx_d = mnx_q;  mxx_d = mxx_q;  mny_d = mny_q;  mxy_d = mxy_q;
            bxn_d = bxn_q;  bxx_d = bxx_q;  byn_d = byn_q;  byx_d = byx_q;
`endif
            if (w_boundary) begin
                fc_d    = acc_q;
                hx_d    = run_x_q;
                hy_d    = run_y_q;
                hv_d    = run_v_q;
                acc_d   = '0;
                run_x_d = '0;
                run_y_d = '0;
                run_v_d = 1'b0;
                // Hysteresis judges the count being latched, not the new frame.
                if (acc_q > c_THRESH) begin
                    found_d = 1'b1;
                    hold_d  = 4'd0;
                end else begin
                    hold_d = w_hold_inc;
                    if (w_hold_inc >= c_HOLD_LIM) found_d = 1'b0;
                end
`ifdef FEATURE_BBOX_EN
                bxn_d = mnx_q;  bxx_d = mxx_q;  byn_d = mny_q;  byx_d = mxy_q;
                mnx_d = c_MIN_RST;  mxx_d = '0;  mny_d = c_MIN_RST;  mxy_d = '0;
`endif
            end else if (w_hit) begin
                if (acc_q != c_CNT_MAX) acc_d = acc_q + 1'b1;
                run_x_d = VGA_X;
                run_y_d = VGA_Y;
                run_v_d = 1'b1;
`ifdef FEATURE_BBOX_EN
                if (VGA_X < mnx_q) mnx_d = VGA_X;
                if (VGA_X > mxx_q) mxx_d = VGA_X;
                if (VGA_Y < mny_q) mny_d = VGA_Y;
                if (VGA_Y > mxy_q) mxy_d = VGA_Y;
`endif
            end
        end

        always_ff @(posedge OSC_27 or negedge RESET_N) begin
            if (!RESET_N) begin
                acc_q   <= '0;
                fc_q    <= '0;
                run_x_q <= '0;
                run_y_q <= '0;
                run_v_q <= 1'b0;
                hx_q    <= '0;
                hy_q    <= '0;
                hv_q    <= 1'b0;
                found_q <= 1'b0;
                hold_q  <= 4'd0;
`ifdef FEATURE_BBOX_EN
                mnx_q <= c_MIN_RST;  mxx_q <= '0;  mny_q <= c_MIN_RST;  mxy_q <= '0;
                bxn_q <= c_MIN_RST;  bxx_q <= '0;  byn_q <= c_MIN_RST;  byx_q <= '0;
`endif
            end else begin
                acc_q   <= acc_d;
                fc_q    <= fc_d;
                run_x_q <= run_x_d;
                run_y_q <= run_y_d;
                run_v_q <= run_v_d;
                hx_q    <= hx_d;
                hy_q    <= hy_d;
                hv_q    <= hv_d;
                found_q <= found_d;
                hold_q  <= hold_d;
`ifdef FEATURE_BBOX_EN
                mnx_q <= mnx_d;  mxx_q <= mxx_d;  mny_q <= mny_d;  mxy_q <= mxy_d;
                bxn_q <= bxn_d;  bxx_q <= bxx_d;  byn_q <= byn_d;  byx_q <= byx_d;
`endif
            end
        end

        assign frame_count[c*CNT_W +: CNT_W] = fc_q;
        assign hit_x[c*10 +: 10]             = hx_q;
        assign hit_y[c*10 +: 10]             = hy_q;
        assign hit_valid[c]                  = hv_q;
        assign found[c]                      = found_q;
`ifdef FEATURE_BBOX_EN
        assign bbox_xmin[c*10 +: 10] = bxn_q;
        assign bbox_xmax[c*10 +: 10] = bxx_q;
        assign bbox_ymin[c*10 +: 10] = byn_q;
        assign bbox_ymax[c*10 +: 10] = byx_q;
`endif
    end

endmodule
`default_nettype wire
